// File: rtl/ntt_mod_correct.sv
// Lazy-to-canonical reducer for the four L-stage NTT output lanes; maps [0,2^32) to [0,Q) per 32-bit half.
// Optional NTT_MOD_CORRECT_BEATCHK_EN adds a per-transfer data-beat counter that flags length errors.
module ntt_mod_correct (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_ready,
  output logic        ap_idle,
  input  logic [64:0] in_0_dout,
  input  logic        in_0_empty_n,
  output logic        in_0_read,
  input  logic [64:0] in_1_dout,
  input  logic        in_1_empty_n,
  output logic        in_1_read,
  input  logic [64:0] in_2_dout,
  input  logic        in_2_empty_n,
  output logic        in_2_read,
  input  logic [64:0] in_3_dout,
  input  logic        in_3_empty_n,
  output logic        in_3_read,
  output logic [64:0] out_0_din,
  input  logic        out_0_full_n,
  output logic        out_0_write,
  output logic [64:0] out_1_din,
  input  logic        out_1_full_n,
  output logic        out_1_write,
  output logic [64:0] out_2_din,
  input  logic        out_2_full_n,
  output logic        out_2_write,
  output logic [64:0] out_3_din,
  input  logic        out_3_full_n,
  output logic        out_3_write,
  output logic        lane_error,
  output logic [1:0]  state_dbg
);

  localparam logic [31:0] Q = 32'd3221225473;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [64:0] data_q [4];
  logic [64:0] data_d [4];
  logic [64:0] in_w [4];
  logic [3:0]  empty_n_w, full_n_w, eot_w;
  logic        all_in, all_out, accept, emit, is_eot, eot_mis;

`ifdef NTT_MOD_CORRECT_BEATCHK_EN
  localparam logic [8:0] BEATS = 9'd128;
  logic [8:0] cnt_q, cnt_d;
`endif

  function automatic logic [31:0] mod_fix(input logic [31:0] c);
    return (c >= Q) ? (c - Q) : c;
  endfunction

  assign in_w[0] = in_0_dout;
  assign in_w[1] = in_1_dout;
  assign in_w[2] = in_2_dout;
  assign in_w[3] = in_3_dout;
  assign empty_n_w = {in_3_empty_n, in_2_empty_n, in_1_empty_n, in_0_empty_n};
  assign full_n_w  = {out_3_full_n, out_2_full_n, out_1_full_n, out_0_full_n};
  assign eot_w     = {in_w[3][64], in_w[2][64], in_w[1][64], in_w[0][64]};

  // Lanes move in lockstep: a beat is taken from all four FIFOs only when every
  // one is non-empty and the shared register is free or draining this cycle;
  // a beat is pushed to all four outputs only when every output has space.
  assign all_in  = &empty_n_w;
  assign all_out = &full_n_w;
  assign accept  = (state_q == S_RUN) && all_in && (!vld_q || all_out);
  assign emit    = vld_q && all_out;
  assign is_eot  = |eot_w;
  assign eot_mis = is_eot && !(&eot_w);

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    err_d   = err_q;
    for (int k = 0; k < 4; k++) data_d[k] = data_q[k];
`ifdef NTT_MOD_CORRECT_BEATCHK_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_RUN;
          err_d   = 1'b0;
`ifdef NTT_MOD_CORRECT_BEATCHK_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RUN: begin
        if (emit) vld_d = 1'b0;
        if (accept) begin
          vld_d = 1'b1;
          if (is_eot) begin
            // Misaligned EOT is folded into a clean EOT so no partial beat leaks out.
            for (int k = 0; k < 4; k++) data_d[k] = {1'b1, 64'b0};
            state_d = S_DRAIN;
            if (eot_mis) err_d = 1'b1;
`ifdef NTT_MOD_CORRECT_BEATCHK_EN
            if (cnt_q != BEATS) err_d = 1'b1;
`endif
          end else begin
            for (int k = 0; k < 4; k++)
              data_d[k] = {1'b0, mod_fix(in_w[k][63:32]), mod_fix(in_w[k][31:0])};
`ifdef NTT_MOD_CORRECT_BEATCHK_EN
            if (cnt_q == BEATS) err_d = 1'b1;
            else cnt_d = cnt_q + 9'd1;
`endif
          end
        end
      end
      S_DRAIN: begin
        if (emit) begin
          vld_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      for (int k = 0; k < 4; k++) data_q[k] <= data_d[k];
    end
  end

`ifdef NTT_MOD_CORRECT_BEATCHK_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`endif

  assign in_0_read   = accept;
  assign in_1_read   = accept;
  assign in_2_read   = accept;
  assign in_3_read   = accept;
  assign out_0_write = emit;
  assign out_1_write = emit;
  assign out_2_write = emit;
  assign out_3_write = emit;
  assign out_0_din   = data_q[0];
  assign out_1_din   = data_q[1];
  assign out_2_din   = data_q[2];
  assign out_3_din   = data_q[3];

  assign ap_idle    = (state_q == S_IDLE);
  assign ap_done    = (state_q == S_DONE);
  assign ap_ready   = (state_q == S_DONE);
  assign lane_error = err_q;
  assign state_dbg  = state_q;

endmodule
